// File: rtl/pu_riscv_ahb3_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pu_riscv_ahb3_arbiter
// Brief    : Three-requester (ins/dat/dbg) AHB3-lite arbiter onto one master
//            port. Define PU_RISCV_AHB3_ARB_RR_EN for round-robin selection
//            instead of fixed priority (dbg > dat > ins).
// Revision : 1.0 - initial release
// ============================================================================
module pu_riscv_ahb3_arbiter #(
  parameter int XLEN = 32,
  parameter int PLEN = XLEN
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,

  input  logic [2:0]                 req_HSEL,
  input  logic [2:0][PLEN-1:0]       req_HADDR,
  input  logic [2:0][XLEN-1:0]       req_HWDATA,
  input  logic [2:0]                 req_HWRITE,
  input  logic [2:0]                 req_HMASTLOCK,
  input  logic [2:0][2:0]            req_HSIZE,
  input  logic [2:0][2:0]            req_HBURST,
  input  logic [2:0][3:0]            req_HPROT,
  input  logic [2:0][1:0]            req_HTRANS,
  output logic [2:0][XLEN-1:0]       req_HRDATA,
  output logic [2:0]                 req_HREADY,
  output logic [2:0]                 req_HRESP,

  output logic                       HSEL,
  output logic [PLEN-1:0]            HADDR,
  output logic [XLEN-1:0]            HWDATA,
  output logic                       HWRITE,
  output logic [2:0]                 HSIZE,
  output logic [2:0]                 HBURST,
  output logic [3:0]                 HPROT,
  output logic [1:0]                 HTRANS,
  output logic                       HMASTLOCK,
  input  logic [XLEN-1:0]            HRDATA,
  input  logic                       HREADY,
  input  logic                       HRESP,

  output logic [1:0]                 grant
);

  localparam logic [1:0] c_TRANS_IDLE   = 2'b00;
  localparam logic [1:0] c_TRANS_BUSY   = 2'b01;
  localparam logic [1:0] c_TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] c_TRANS_SEQ    = 2'b11;
  localparam logic [2:0] c_BURST_SINGLE = 3'b000;

  localparam logic [0:0] c_ST_OPEN  = 1'b0;
  localparam logic [0:0] c_ST_OWNED = 1'b1;

  logic [0:0] state_q,      state_d;
  logic [1:0] addr_owner_q, addr_owner_d;
  logic [1:0] data_owner_q, data_owner_d;
  logic       data_valid_q, data_valid_d;

  logic [2:0] w_req;
  logic [1:0] w_winner;
  logic [1:0] w_own_trans;
  logic       w_own_open;

  genvar r;
  generate
    for (r = 0; r < 3; r++) begin : g_req
      assign w_req[r] = req_HSEL[r] & (req_HTRANS[r] == c_TRANS_NONSEQ);
    end
  endgenerate

  assign w_own_trans = req_HTRANS[addr_owner_q];

  // Ownership may only change between transfers: idle or a lone unlocked single.
  assign w_own_open = ~req_HMASTLOCK[addr_owner_q] &
                      ((w_own_trans == c_TRANS_IDLE) |
                       ((w_own_trans == c_TRANS_NONSEQ) &
                        (req_HBURST[addr_owner_q] == c_BURST_SINGLE)));

`ifdef PU_RISCV_AHB3_ARB_RR_EN
  logic [1:0] w_rr_c1;
  logic [1:0] w_rr_c2;

  // Search starts just after the current owner; the owner itself is last.
  always_comb begin
    w_rr_c1  = (addr_owner_q == 2'd2) ? 2'd0 : addr_owner_q + 2'd1;
    w_rr_c2  = (w_rr_c1 == 2'd2) ? 2'd0 : w_rr_c1 + 2'd1;
    w_winner = addr_owner_q;
    if (w_req[w_rr_c1])      w_winner = w_rr_c1;
    else if (w_req[w_rr_c2]) w_winner = w_rr_c2;
  end
`else
  always_comb begin
    w_winner = addr_owner_q;
    if (w_req[2])      w_winner = 2'd2;
    else if (w_req[1]) w_winner = 2'd1;
    else if (w_req[0]) w_winner = 2'd0;
  end
`endif

  always_comb begin
    state_d      = state_q;
    addr_owner_d = addr_owner_q;
    data_owner_d = data_owner_q;
    data_valid_d = data_valid_q;
    if (HREADY) begin
      data_owner_d = addr_owner_q;
      data_valid_d = (w_own_trans == c_TRANS_NONSEQ) | (w_own_trans == c_TRANS_SEQ);
      case (state_q)
        c_ST_OPEN: begin
          if (w_own_open) addr_owner_d = w_winner;
          else            state_d      = c_ST_OWNED;
        end
        c_ST_OWNED: begin
          if (w_own_open) begin
            state_d      = c_ST_OPEN;
            addr_owner_d = w_winner;
          end
        end
        default: state_d = c_ST_OPEN;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q      <= c_ST_OPEN;
      addr_owner_q <= 2'd0;
      data_owner_q <= 2'd0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_owner_q <= addr_owner_d;
      data_owner_q <= data_owner_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign HSEL      = req_HSEL[addr_owner_q];
  assign HADDR     = req_HADDR[addr_owner_q];
  assign HWRITE    = req_HWRITE[addr_owner_q];
  assign HSIZE     = req_HSIZE[addr_owner_q];
  assign HBURST    = req_HBURST[addr_owner_q];
  assign HPROT     = req_HPROT[addr_owner_q];
  assign HTRANS    = req_HTRANS[addr_owner_q];
  assign HMASTLOCK = req_HMASTLOCK[addr_owner_q];
  assign HWDATA    = data_valid_q ? req_HWDATA[data_owner_q] : '0;
  assign grant     = addr_owner_q;

  generate
    for (r = 0; r < 3; r++) begin : g_resp
      localparam logic [1:0] c_IDX = 2'(r);
      logic w_is_addr;
      logic w_is_data;

      assign w_is_addr     = (addr_owner_q == c_IDX);
      assign w_is_data     = data_valid_q & (data_owner_q == c_IDX);
      assign req_HRDATA[r] = HRDATA;
      assign req_HRESP[r]  = w_is_data & HRESP;
      // Non-owners with a pending transfer are held in their address phase.
      assign req_HREADY[r] = (w_is_addr | w_is_data) ? HREADY :
                             ((req_HTRANS[r] == c_TRANS_IDLE) |
                              (req_HTRANS[r] == c_TRANS_BUSY));
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pu_riscv_ahb3_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pu_riscv_ahb3_arbiter
// Brief    : Directed vector bench for pu_riscv_ahb3_arbiter (both builds,
//            selected by PU_RISCV_AHB3_ARB_RR_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pu_riscv_ahb3_arbiter;

  localparam int XLEN = 32;
  localparam int PLEN = 32;
  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;

  logic                 HCLK = 1'b0;
  logic                 HRESETn;
  logic [2:0]           req_HSEL;
  logic [2:0][PLEN-1:0] req_HADDR;
  logic [2:0][XLEN-1:0] req_HWDATA;
  logic [2:0]           req_HWRITE;
  logic [2:0]           req_HMASTLOCK;
  logic [2:0][2:0]      req_HSIZE;
  logic [2:0][2:0]      req_HBURST;
  logic [2:0][3:0]      req_HPROT;
  logic [2:0][1:0]      req_HTRANS;
  logic [2:0][XLEN-1:0] req_HRDATA;
  logic [2:0]           req_HREADY;
  logic [2:0]           req_HRESP;
  logic                 HSEL;
  logic [PLEN-1:0]      HADDR;
  logic [XLEN-1:0]      HWDATA;
  logic                 HWRITE;
  logic [2:0]           HSIZE;
  logic [2:0]           HBURST;
  logic [3:0]           HPROT;
  logic [1:0]           HTRANS;
  logic                 HMASTLOCK;
  logic [XLEN-1:0]      HRDATA;
  logic                 HREADY;
  logic                 HRESP;
  logic [1:0]           grant;

  pu_riscv_ahb3_arbiter #(.XLEN(XLEN), .PLEN(PLEN)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_HSEL(req_HSEL), .req_HADDR(req_HADDR), .req_HWDATA(req_HWDATA),
    .req_HWRITE(req_HWRITE), .req_HMASTLOCK(req_HMASTLOCK), .req_HSIZE(req_HSIZE),
    .req_HBURST(req_HBURST), .req_HPROT(req_HPROT), .req_HTRANS(req_HTRANS),
    .req_HRDATA(req_HRDATA), .req_HREADY(req_HREADY), .req_HRESP(req_HRESP),
    .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .grant(grant)
  );

  always #5 HCLK = ~HCLK;

  // One cycle of stimulus plus the outputs expected during that cycle.
  // wd: requester whose write data should be on HWDATA, 3 = none (zero).
  typedef struct {
    logic [1:0] t0, t1, t2;
    logic       rdy_in, resp_in;
    logic [1:0] grant;
    logic [1:0] htrans;
    logic [2:0] rdy;
    logic [2:0] resp;
    logic [1:0] wd;
  } vec_t;

  vec_t        vecs[25];
  logic [31:0] base[3];
  logic [31:0] wdat[3];
  logic [1:0]  exp_seq[6];
  int          total = 0;
  int          bad   = 0;

  function automatic vec_t mk(input logic [1:0] t0, t1, t2, input logic ri, rs,
                              input logic [1:0] g, ht, input logic [2:0] rd, rp,
                              input logic [1:0] wd);
    vec_t v;
    v.t0 = t0; v.t1 = t1; v.t2 = t2; v.rdy_in = ri; v.resp_in = rs;
    v.grant = g; v.htrans = ht; v.rdy = rd; v.resp = rp; v.wd = wd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_trans(input logic [1:0] t0, t1, t2);
    req_HTRANS[0] = t0; req_HSEL[0] = (t0 != ID);
    req_HTRANS[1] = t1; req_HSEL[1] = (t1 != ID);
    req_HTRANS[2] = t2; req_HSEL[2] = (t2 != ID);
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    base[0] = 32'h0000_0200; base[1] = 32'h0000_1000; base[2] = 32'h0000_3000;
    wdat[0] = 32'hD0D0_0000; wdat[1] = 32'hD0D0_0001; wdat[2] = 32'hD0D0_0002;
    for (int i = 0; i < 3; i++) begin
      req_HADDR[i]  = base[i];
      req_HWDATA[i] = wdat[i];
    end
    req_HWRITE = 3'b010; req_HMASTLOCK = '0; req_HSIZE = {3{3'b010}};
    req_HBURST = '0; req_HPROT = {3{4'b0011}};
    set_trans(ID, ID, ID);
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0; HRESETn = 1'b0;

    //                 t0  t1  t2  rdy rsp grant htrans rdy     resp    wd
    vecs[0]  = mk(ID, ID, ID, 1, 0, 2'd0, ID, 3'b111, 3'b000, 2'd3);
    vecs[1]  = mk(NS, ID, ID, 1, 0, 2'd0, NS, 3'b111, 3'b000, 2'd3);
    vecs[2]  = mk(ID, ID, ID, 1, 0, 2'd0, ID, 3'b111, 3'b000, 2'd0);
    vecs[3]  = mk(ID, NS, ID, 1, 0, 2'd0, ID, 3'b101, 3'b000, 2'd3);
    vecs[4]  = mk(ID, NS, ID, 1, 0, 2'd1, NS, 3'b111, 3'b000, 2'd3);
    vecs[5]  = mk(ID, ID, ID, 1, 0, 2'd1, ID, 3'b111, 3'b000, 2'd1);
    vecs[6]  = mk(NS, ID, NS, 1, 0, 2'd1, ID, 3'b010, 3'b000, 2'd3);
    vecs[7]  = mk(NS, ID, NS, 1, 0, 2'd2, NS, 3'b110, 3'b000, 2'd3);
`ifdef PU_RISCV_AHB3_ARB_RR_EN
    vecs[8]  = mk(NS, ID, ID, 1, 0, 2'd0, NS, 3'b111, 3'b000, 2'd2);
    vecs[9]  = mk(NS, ID, ID, 1, 0, 2'd0, NS, 3'b111, 3'b000, 2'd0);
    exp_seq  = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
`else
    vecs[8]  = mk(NS, ID, ID, 1, 0, 2'd2, ID, 3'b110, 3'b000, 2'd2);
    vecs[9]  = mk(NS, ID, ID, 1, 0, 2'd0, NS, 3'b111, 3'b000, 2'd3);
    exp_seq  = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
`endif
    vecs[10] = mk(ID, ID, ID, 1, 0, 2'd0, ID, 3'b111, 3'b000, 2'd0);
    vecs[11] = mk(ID, NS, ID, 1, 0, 2'd0, ID, 3'b101, 3'b000, 2'd3);
    vecs[12] = mk(ID, NS, ID, 1, 0, 2'd1, NS, 3'b111, 3'b000, 2'd3);
    vecs[13] = mk(NS, ID, ID, 0, 0, 2'd1, ID, 3'b100, 3'b000, 2'd1);
    vecs[14] = mk(NS, ID, ID, 0, 0, 2'd1, ID, 3'b100, 3'b000, 2'd1);
    vecs[15] = mk(NS, ID, ID, 0, 0, 2'd1, ID, 3'b100, 3'b000, 2'd1);
    vecs[16] = mk(NS, ID, ID, 1, 0, 2'd1, ID, 3'b110, 3'b000, 2'd1);
    vecs[17] = mk(NS, ID, ID, 1, 0, 2'd0, NS, 3'b111, 3'b000, 2'd3);
    vecs[18] = mk(ID, ID, ID, 1, 0, 2'd0, ID, 3'b111, 3'b000, 2'd0);
    vecs[19] = mk(ID, NS, ID, 1, 0, 2'd0, ID, 3'b101, 3'b000, 2'd3);
    vecs[20] = mk(ID, NS, ID, 1, 0, 2'd1, NS, 3'b111, 3'b000, 2'd3);
    vecs[21] = mk(ID, ID, NS, 0, 1, 2'd1, ID, 3'b001, 3'b010, 2'd1);
    vecs[22] = mk(ID, ID, NS, 1, 1, 2'd1, ID, 3'b011, 3'b010, 2'd1);
    vecs[23] = mk(ID, ID, NS, 1, 0, 2'd2, NS, 3'b111, 3'b000, 2'd3);
    vecs[24] = mk(ID, ID, ID, 1, 0, 2'd2, ID, 3'b111, 3'b000, 2'd2);

    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    for (int i = 0; i < 25; i++) begin
      logic [31:0] rd;
      rd = 32'hA500_0000 + 32'(i);
      set_trans(vecs[i].t0, vecs[i].t1, vecs[i].t2);
      HREADY = vecs[i].rdy_in;
      HRESP  = vecs[i].resp_in;
      HRDATA = rd;
      @(negedge HCLK);
      chk($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].grant));
      chk($sformatf("v%0d HTRANS", i), 32'(HTRANS), 32'(vecs[i].htrans));
      chk($sformatf("v%0d HADDR", i), HADDR, base[vecs[i].grant]);
      chk($sformatf("v%0d req_HREADY", i), 32'(req_HREADY), 32'(vecs[i].rdy));
      chk($sformatf("v%0d req_HRESP", i), 32'(req_HRESP), 32'(vecs[i].resp));
      chk($sformatf("v%0d HWDATA", i), HWDATA,
          (vecs[i].wd == 2'd3) ? 32'h0 : wdat[vecs[i].wd]);
      for (int k = 0; k < 3; k++)
        chk($sformatf("v%0d req_HRDATA%0d", i, k), req_HRDATA[k], rd);
      tick();
    end

    // dat INCR4 write; dbg requests from beat 1 and must wait for the burst.
    HREADY = 1'b1; HRESP = 1'b0;
    set_trans(ID, NS, ID);
    req_HBURST[1] = 3'b011;
    @(negedge HCLK);
    chk("burst pre grant", 32'(grant), 32'd2);
    tick();
    for (int k = 0; k < 4; k++) begin
      req_HTRANS[1] = (k == 0) ? NS : SQ;
      req_HADDR[1]  = 32'h0000_1000 + 32'(4 * k);
      if (k >= 1) begin
        req_HSEL[2] = 1'b1; req_HTRANS[2] = NS;
      end
      @(negedge HCLK);
      chk($sformatf("burst beat%0d grant", k), 32'(grant), 32'd1);
      chk($sformatf("burst beat%0d HADDR", k), HADDR, 32'h0000_1000 + 32'(4 * k));
      chk($sformatf("burst beat%0d HTRANS", k), 32'(HTRANS), (k == 0) ? 32'(NS) : 32'(SQ));
      if (k >= 1) chk($sformatf("burst beat%0d dbg stall", k), 32'(req_HREADY[2]), 32'd0);
      tick();
    end
    req_HTRANS[1] = ID; req_HSEL[1] = 1'b0; req_HBURST[1] = 3'b000;
    req_HADDR[1]  = base[1];
    @(negedge HCLK);
    chk("burst end grant", 32'(grant), 32'd1);
    chk("burst end HWDATA", HWDATA, wdat[1]);
    tick();
    @(negedge HCLK);
    chk("after burst grant", 32'(grant), 32'd2);
    chk("after burst HADDR", HADDR, base[2]);
    chk("after burst HTRANS", 32'(HTRANS), 32'(NS));
    tick();

    // Reset in the data phase of the dbg transfer abandons it.
    set_trans(ID, ID, ID);
    HREADY = 1'b0; HRESP = 1'b1; HRESETn = 1'b0;
    @(negedge HCLK);
    chk("pre-reset req_HRESP", 32'(req_HRESP), 32'b100);
    tick();
    HRESETn = 1'b1; HREADY = 1'b1;
    @(negedge HCLK);
    chk("post-reset grant", 32'(grant), 32'd0);
    chk("post-reset req_HRESP", 32'(req_HRESP), 32'd0);
    chk("post-reset HWDATA", HWDATA, 32'h0);
    tick();
    HRESP = 1'b0;

    // All three requesters issue back-to-back singles.
    set_trans(NS, NS, NS);
    @(negedge HCLK);
    chk("contend start grant", 32'(grant), 32'd0);
    tick();
    for (int j = 0; j < 6; j++) begin
      @(negedge HCLK);
      chk($sformatf("contend %0d grant", j), 32'(grant), 32'(exp_seq[j]));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
